sw_pe_array: RTL and testbench
==============================

Name: sw_pe_array

Overview:
- Parametrised linear systolic array of NUM_PE Smith-Waterman cells with affine gap scoring.
- Each cell holds one 2-bit database base; query bases stream through the array one per cycle.
- The block adds cascade outputs for segmenting long databases, per-run active-cell count, saturating arithmetic, a registered max-reduction pipeline and a best-score/done report.
- It sits between the sequence loader (database bases, query stream) and the result collector.

Parameters:
- NUM_PE, 8, number of cells (>=2).
- W, 10, score width (unsigned) for H/E/F/penalties.
- CNT_W, $clog2(NUM_PE+1), width of num_active.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous active-low
- s_load  in  1  load database bases
- s_data  in  2*NUM_PE  base of cell i at [2i+1:2i]; A=0 C=1 G=2 T=3
- num_active  in  CNT_W  cells 0..num_active-1 compute; rest bypass
- alpha  in  W  gap-open penalty
- beta  in  W  gap-extend penalty
- match  in  W  match bonus
- mismatch  in  W  mismatch penalty
- in_valid  in  1  query token valid
- in_first  in  1  token is first base of a query
- in_last  in  1  token is last base of a query
- t_in  in  2  query base
- h_in  in  W  upstream H (cascade; 0 if unused)
- f_in  in  W  upstream F (cascade; 0 if unused)
- busy  out  1  token in flight or reduction pending
- out_valid, out_first, out_last  out  1 each  token flags leaving the last cell
- t_out  out  2  query base leaving the last cell
- h_out, f_out  out  W  H/F leaving the last cell
- best_score  out  W  running max of H over the current query
- done  out  1  one-cycle pulse when best_score is final

Behaviour:
- Reset (rst_n=0 at posedge): all cell registers, out_* flags, t_out/h_out/f_out, best_score, done and busy are 0. Database registers are cleared to 0. Reset mid-query aborts the query and emits no done.
- Arithmetic: all ops are unsigned. Subtraction floors at 0; addition saturates at 2^W-1.
  - sub = match if s_i==t_j, else -mismatch.
- Cell i at token j:
  - E = max(Hl-alpha, El-beta), where Hl/El are the cell's stored H/E of the previous column.
  - F = max(Hu-alpha, Fu-beta), where Hu/Fu are the upstream H/F for this token.
  - H = max(0, Hd+sub, E, F), where Hd is the upstream H of the previous token.
  - The cell registers and forwards t, flags, H and F to cell i+1 one cycle later.
  - Cell 0 upstream is h_in/f_in; its Hd is the previous h_in.
- in_first token: each cell treats Hl=El=Hd=0 as the token passes, before computing.
- Inactive cell (index >= num_active): forwards upstream t/flags/H/F unchanged with one-cycle delay. Its H is excluded from the max.
- Latency: a token accepted at edge c appears on out_* at edge c+NUM_PE. No backpressure; tokens may be back-to-back or gapped. Gaps do not advance cell state.
- Reduction: each cycle, max over valid active cell H outputs is registered (stage 1). The next edge sets best_score to the stage-1 value only if it is strictly greater.
- in_first accepted at cell 0 clears best_score to 0 that edge.
- done: pulses 2 cycles after out_valid&out_last, when best_score includes all H values of the query.
- busy: 1 from token acceptance until the done edge.
- Protocol guards:
  - in_valid&in_first while busy=1: token dropped, no state change.
  - s_load while busy=1: ignored. s_load while busy=0: all bases latched that edge.
  - s_load and in_first in the same idle cycle: bases load first, and the token uses the new bases.
- num_active and the penalty inputs must be stable while busy=1; they are sampled combinationally.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1 -> all outputs 0. After release, busy=0 and no done.
2. NUM_PE=4, W=10, s=ACGT, num_active=4, match=2, mismatch=1, alpha=2, beta=1, query ACGT at cycles 0..3 -> out_valid cycles 4..7; done at cycle 9; best_score=8.
3. Gap case, s=ACGT, query AGT:
   - alpha=1, beta=1 -> best_score=5.
   - Rerun with alpha=2 -> best_score=4.
   - best_score clears on in_first of the rerun.
4. Mismatch only, s=AAAA, query TTTT -> best_score=0, done still pulses. num_active=2 with s=AC.., query ACGT -> best_score=4, t_out latency still 4.
5. Saturation, W=4, match=7, s=AAAA, query AAAA -> best_score=15, no wrap. h_out of the last cell is 15.
6. Guards:
   - in_first injected while busy -> dropped, original result unchanged.
   - s_load while busy -> bases unchanged; a later idle s_load takes effect.
   - Reset asserted mid-query -> no done, outputs 0.

Source files
------------

// File: rtl/sw_pe_if.sv
// Bundles the sequence-loader, query-stream and result signals of sw_pe_array.
// Ports (slave = the array):
//   loader  : s_load, s_data, num_active, alpha, beta, match, mismatch
//   stream  : in_valid, in_first, in_last, t_in, h_in, f_in
//   results : busy, out_valid, out_first, out_last, t_out, h_out, f_out,
//             best_score, done
interface sw_pe_if #(
    parameter int NUM_PE = 8,
    parameter int W      = 10,
    parameter int CNT_W  = $clog2(NUM_PE + 1)
) ();
    logic                s_load;
    logic [2*NUM_PE-1:0] s_data;
    logic [CNT_W-1:0]    num_active;
    logic [W-1:0]        alpha;
    logic [W-1:0]        beta;
    logic [W-1:0]        match;
    logic [W-1:0]        mismatch;
    logic                in_valid;
    logic                in_first;
    logic                in_last;
    logic [1:0]          t_in;
    logic [W-1:0]        h_in;
    logic [W-1:0]        f_in;
    logic                busy;
    logic                out_valid;
    logic                out_first;
    logic                out_last;
    logic [1:0]          t_out;
    logic [W-1:0]        h_out;
    logic [W-1:0]        f_out;
    logic [W-1:0]        best_score;
    logic                done;

    modport master (
        output s_load, s_data, num_active, alpha, beta, match, mismatch,
        output in_valid, in_first, in_last, t_in, h_in, f_in,
        input  busy, out_valid, out_first, out_last, t_out, h_out, f_out,
        input  best_score, done
    );

    modport slave (
        input  s_load, s_data, num_active, alpha, beta, match, mismatch,
        input  in_valid, in_first, in_last, t_in, h_in, f_in,
        output busy, out_valid, out_first, out_last, t_out, h_out, f_out,
        output best_score, done
    );
endinterface

// File: rtl/sw_pe_array.sv
// Linear systolic array of NUM_PE Smith-Waterman cells with affine gaps.
// Each cell holds one database base; query bases stream through one per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sw_pe_if slave (database load, query stream, cascade H/F in,
//                last-cell outputs, best score / done report, busy)
// Pipeline: stage 0 is the input register (token acceptance), stage i+1 is
// the output register of cell i, so out_* lag acceptance by NUM_PE edges.
module sw_pe_array #(
    parameter int NUM_PE = 8,
    parameter int W      = 10,
    parameter int CNT_W  = $clog2(NUM_PE + 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    sw_pe_if.slave bus
);

    logic [NUM_PE:0]          vld_q, vld_d, first_q, first_d, last_q, last_d;
    logic [NUM_PE:0][1:0]     t_q, t_d;
    logic [NUM_PE:0][W-1:0]   h_q, h_d, f_q, f_d;
    logic [NUM_PE-1:0][W-1:0] hl_q, hl_d, el_q, el_d, hd_q, hd_d;
    logic [2*NUM_PE-1:0]      db_q, db_d;
    logic [W-1:0]             red_q, red_d, best_q, best_d;
    logic                     red_last_q, red_last_d;
    logic                     done_q, done_d, busy_q, busy_d;

    logic [CNT_W-1:0]         num_act;
    logic [NUM_PE-1:0]        act;
    logic [NUM_PE-1:0][W-1:0] hl_c, el_c, hd_c, diag_c;
    logic [NUM_PE-1:0][W-1:0] e_new, f_new, h_new;
    logic                     accept, load;

    function automatic logic [W-1:0] sub_fl(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [W-1:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? '1 : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign num_act = bus.num_active;

    // Cell datapath. A first-of-query token sees zeroed left/diagonal history.
    always_comb begin
        act    = '0;
        hl_c   = '0;
        el_c   = '0;
        hd_c   = '0;
        diag_c = '0;
        e_new  = '0;
        f_new  = '0;
        h_new  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            act[i]    = num_act > CNT_W'(i);
            hl_c[i]   = first_q[i] ? '0 : hl_q[i];
            el_c[i]   = first_q[i] ? '0 : el_q[i];
            hd_c[i]   = first_q[i] ? '0 : hd_q[i];
            diag_c[i] = (db_q[2*i +: 2] == t_q[i]) ? add_sat(hd_c[i], bus.match)
                                                   : sub_fl(hd_c[i], bus.mismatch);
            e_new[i]  = max2(sub_fl(hl_c[i], bus.alpha), sub_fl(el_c[i], bus.beta));
            f_new[i]  = max2(sub_fl(h_q[i], bus.alpha), sub_fl(f_q[i], bus.beta));
            h_new[i]  = max2(diag_c[i], max2(e_new[i], f_new[i]));
        end
    end

    always_comb begin
        vld_d   = '0;
        first_d = '0;
        last_d  = '0;
        t_d     = '0;
        h_d     = '0;
        f_d     = '0;
        hl_d    = hl_q;
        el_d    = el_q;
        hd_d    = hd_q;
        red_d   = '0;

        // A new query may only start once the previous one has reported.
        accept = bus.in_valid && !(bus.in_first && busy_q);
        load   = bus.s_load && !busy_q;
        db_d   = load ? bus.s_data : db_q;

        vld_d[0]   = accept;
        first_d[0] = accept && bus.in_first;
        last_d[0]  = accept && bus.in_last;
        t_d[0]     = bus.t_in;
        h_d[0]     = bus.h_in;
        f_d[0]     = bus.f_in;

        for (int i = 0; i < NUM_PE; i++) begin
            vld_d[i+1]   = vld_q[i];
            first_d[i+1] = first_q[i];
            last_d[i+1]  = last_q[i];
            t_d[i+1]     = t_q[i];
            h_d[i+1]     = act[i] ? h_new[i] : h_q[i];
            f_d[i+1]     = act[i] ? f_new[i] : f_q[i];
            // History only advances on real tokens, so gaps are transparent.
            if (vld_q[i] && act[i]) begin
                hl_d[i] = h_new[i];
                el_d[i] = e_new[i];
                hd_d[i] = h_q[i];
            end
            if (vld_q[i+1] && act[i] && (h_q[i+1] > red_d)) begin
                red_d = h_q[i+1];
            end
        end

        red_last_d = vld_q[NUM_PE] && last_q[NUM_PE];
        // done lines up with the edge that folds the last token's stage-1 max in.
        done_d     = red_last_q;

        if (accept && bus.in_first) begin
            best_d = '0;
        end else if (red_q > best_q) begin
            best_d = red_q;
        end else begin
            best_d = best_q;
        end

        if (accept) begin
            busy_d = 1'b1;
        end else if (done_d) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            t_q        <= '0;
            h_q        <= '0;
            f_q        <= '0;
            hl_q       <= '0;
            el_q       <= '0;
            hd_q       <= '0;
            db_q       <= '0;
            red_q      <= '0;
            red_last_q <= 1'b0;
            best_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
            t_q        <= t_d;
            h_q        <= h_d;
            f_q        <= f_d;
            hl_q       <= hl_d;
            el_q       <= el_d;
            hd_q       <= hd_d;
            db_q       <= db_d;
            red_q      <= red_d;
            red_last_q <= red_last_d;
            best_q     <= best_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.out_valid  = vld_q[NUM_PE];
    assign bus.out_first  = first_q[NUM_PE];
    assign bus.out_last   = last_q[NUM_PE];
    assign bus.t_out      = t_q[NUM_PE];
    assign bus.h_out      = h_q[NUM_PE];
    assign bus.f_out      = f_q[NUM_PE];
    assign bus.best_score = best_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sw_pe_array.sv
module tb_sw_pe_array;
    localparam int NP    = 4;
    localparam int W     = 10;
    localparam int CNT_W = $clog2(NP + 1);
    localparam int MAXV  = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sw_pe_if #(.NUM_PE(NP), .W(W)) bus ();
    sw_pe_array #(.NUM_PE(NP), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errs   = 0;
    int db_m[NP];
    int na_m, alpha_m, beta_m, match_m, mism_m;
    logic [2*NP-1:0] cur_db;
    int q_g[$], hin_g[$], fin_g[$];
    int eh_g[$], ef_g[$];
    int ebest_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int enc(input byte ch);
        case (ch)
            "C":     return 1;
            "G":     return 2;
            "T":     return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int clampv(input int x);
        return (x < 0) ? 0 : ((x > MAXV) ? MAXV : x);
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2*NP-1:0] db_str(input string s);
        logic [2*NP-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[2*i +: 2] = 2'(enc(s[i]));
        return v;
    endfunction

    task automatic set_q(input string s, input bit rnd_up);
        q_g.delete(); hin_g.delete(); fin_g.delete();
        for (int i = 0; i < s.len(); i++) begin
            q_g.push_back(enc(s[i]));
            hin_g.push_back(rnd_up ? int'($urandom_range(0, 30)) : 0);
            fin_g.push_back(rnd_up ? int'($urandom_range(0, 30)) : 0);
        end
    endtask

    task automatic set_db_model(input logic [2*NP-1:0] v);
        for (int i = 0; i < NP; i++) db_m[i] = int'(v[2*i +: 2]);
        cur_db = v;
    endtask

    task automatic set_cfg(input int na, input int a, input int b, input int m, input int mm);
        na_m = na; alpha_m = a; beta_m = b; match_m = m; mism_m = mm;
        bus.num_active = CNT_W'(na);
        bus.alpha      = W'(a);
        bus.beta       = W'(b);
        bus.match      = W'(m);
        bus.mismatch   = W'(mm);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.s_load   = 1'b0;
    endtask

    // Affine-gap local alignment matrix: row i = database base i, column j = query base j.
    task automatic model();
        int H[NP][32];
        int E[NP][32];
        int F[NP][32];
        int n;
        n = q_g.size();
        eh_g.delete(); ef_g.delete(); ebest_g = 0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < na_m; i++) begin
                int hu, fu, hd, hl, el, dg;
                hu = (i == 0) ? hin_g[j] : H[i-1][j];
                fu = (i == 0) ? fin_g[j] : F[i-1][j];
                hd = (j == 0) ? 0 : ((i == 0) ? hin_g[j-1] : H[i-1][j-1]);
                hl = (j == 0) ? 0 : H[i][j-1];
                el = (j == 0) ? 0 : E[i][j-1];
                E[i][j] = mx(clampv(hl - alpha_m), clampv(el - beta_m));
                F[i][j] = mx(clampv(hu - alpha_m), clampv(fu - beta_m));
                dg = clampv((db_m[i] == q_g[j]) ? hd + match_m : hd - mism_m);
                H[i][j] = mx(mx(0, dg), mx(E[i][j], F[i][j]));
                ebest_g = mx(ebest_g, H[i][j]);
            end
            eh_g.push_back((na_m == 0) ? hin_g[j] : H[na_m-1][j]);
            ef_g.push_back((na_m == 0) ? fin_g[j] : F[na_m-1][j]);
        end
    endtask

    task automatic load_db(input logic [2*NP-1:0] v);
        bus.s_load = 1'b1;
        bus.s_data = v;
        @(posedge clk);
        @(negedge clk);
        bus.s_load = 1'b0;
        set_db_model(v);
    endtask

    task automatic run_query(input bit gaps, input bit do_load, input logic [2*NP-1:0] load_val,
                             input bit guard, input int abort_at, input int plan_best);
        int n, k_in, k_out, e;
        int acc[$];
        bit done_seen, guard_done, saw_done;
        n = q_g.size();
        if (do_load) set_db_model(load_val);
        model();
        k_in = 0; k_out = 0; e = 0; done_seen = 0; guard_done = 0;
        while (!done_seen && e < 300) begin
            if (abort_at >= 0 && k_in == abort_at) begin
                bus.in_valid = 1'b1;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_eq("abort_out_valid", 32'(bus.out_valid), 0);
                check_eq("abort_h_out", 32'(bus.h_out), 0);
                check_eq("abort_best", 32'(bus.best_score), 0);
                check_eq("abort_busy", 32'(bus.busy), 0);
                rst_n = 1'b1;
                idle_inputs();
                set_db_model('0);
                saw_done = 0;
                repeat (12) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (bus.done) saw_done = 1;
                end
                check_eq("abort_no_done", 32'(saw_done), 0);
                return;
            end
            idle_inputs();
            if (k_in < n && !(gaps && k_in > 0 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_first = (k_in == 0);
                bus.in_last  = (k_in == n - 1);
                bus.t_in     = 2'(q_g[k_in]);
                bus.h_in     = W'(hin_g[k_in]);
                bus.f_in     = W'(fin_g[k_in]);
                if (k_in == 0 && do_load) begin
                    bus.s_load = 1'b1;
                    bus.s_data = load_val;
                end
                acc.push_back(e + 1);
                k_in++;
            end else if (guard && k_in == n && !guard_done) begin
                bus.in_valid = 1'b1;
                bus.in_first = 1'b1;
                bus.in_last  = 1'b1;
                bus.t_in     = 2'($urandom);
                bus.h_in     = W'($urandom_range(0, 50));
                bus.s_load   = 1'b1;
                bus.s_data   = ~cur_db;
                guard_done   = 1;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            if (acc.size() > 0 && e == acc[0]) check_eq("best_clear", 32'(bus.best_score), 0);
            if (bus.out_valid) begin
                if (k_out < n) begin
                    check_eq("latency", 32'(e), 32'(acc[k_out] + NP));
                    check_eq("t_out", 32'(bus.t_out), 32'(q_g[k_out]));
                    check_eq("h_out", 32'(bus.h_out), 32'(eh_g[k_out]));
                    check_eq("f_out", 32'(bus.f_out), 32'(ef_g[k_out]));
                    check_eq("flags", 32'({bus.out_first, bus.out_last}),
                             32'({k_out == 0, k_out == n - 1}));
                    k_out++;
                end else begin
                    check_eq("extra_out", 32'(bus.out_valid), 0);
                end
            end
            if (bus.done) begin
                if (acc.size() == n) check_eq("done_edge", 32'(e), 32'(acc[n-1] + NP + 2));
                else check_eq("done_early", 32'(acc.size()), 32'(n));
                check_eq("best", 32'(bus.best_score), 32'(ebest_g));
                check_eq("busy_at_done", 32'(bus.busy), 0);
                check_eq("all_out", 32'(k_out), 32'(n));
                if (plan_best >= 0) check_eq("best_plan", 32'(bus.best_score), 32'(plan_best));
                done_seen = 1;
            end else if (k_in > 0) begin
                check_eq("busy", 32'(bus.busy), 1);
            end
        end
        check_eq("done_timeout", 32'(done_seen), 1);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check_eq("done_pulse", 32'(bus.done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_load = 1'b0; bus.s_data = '0;
        bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1;
        bus.t_in = 2'd2; bus.h_in = W'(7); bus.f_in = W'(3);
        set_cfg(NP, 2, 1, 2, 1);
        set_db_model('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_first", 32'(bus.out_first), 0);
        check_eq("rst_out_last", 32'(bus.out_last), 0);
        check_eq("rst_t_out", 32'(bus.t_out), 0);
        check_eq("rst_h_out", 32'(bus.h_out), 0);
        check_eq("rst_f_out", 32'(bus.f_out), 0);
        check_eq("rst_best", 32'(bus.best_score), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("idle_busy", 32'(bus.busy), 0);
            check_eq("idle_done", 32'(bus.done), 0);
        end

        // Exact diagonal match.
        load_db(db_str("ACGT"));
        set_q("ACGT", 0);
        run_query(0, 0, '0, 0, -1, 8);

        // Gap open/extend, then rerun with a heavier open penalty.
        set_cfg(NP, 1, 1, 2, 1);
        set_q("AGT", 0);
        run_query(0, 0, '0, 0, -1, 5);
        set_cfg(NP, 2, 1, 2, 1);
        run_query(0, 0, '0, 0, -1, 4);

        // Mismatch only, with a load in the same cycle as in_first.
        set_q("TTTT", 0);
        run_query(0, 1, db_str("AAAA"), 0, -1, 0);

        // Partially active array.
        set_cfg(2, 2, 1, 2, 1);
        set_q("ACGT", 0);
        run_query(0, 1, db_str("ACGT"), 0, -1, 4);

        // Saturation at the top of the score range.
        set_cfg(NP, 2, 1, MAXV, 0);
        set_q("AAAA", 0);
        run_query(0, 1, db_str("AAAA"), 0, -1, MAXV);

        // In-flight in_first and s_load are ignored; a later idle load applies.
        set_cfg(NP, 2, 1, 2, 1);
        set_q("ACGT", 0);
        run_query(0, 1, db_str("ACGT"), 1, -1, 8);
        load_db(db_str("AAAA"));
        set_q("AAAA", 0);
        run_query(0, 0, '0, 0, -1, 8);

        // Reset in the middle of a query.
        set_q("ACGTAC", 0);
        run_query(0, 0, '0, 0, 3, -1);

        // Randomised queries, configurations, cascade inputs and gaps.
        for (int it = 0; it < 30; it++) begin
            logic [2*NP-1:0] v;
            int n;
            v = (2*NP)'($urandom);
            set_cfg($urandom_range(0, NP), $urandom_range(0, 5), $urandom_range(0, 3),
                    (it % 7 == 6) ? int'($urandom_range(300, MAXV)) : int'($urandom_range(0, 8)),
                    $urandom_range(0, 5));
            if (it % 3 == 0) load_db((2*NP)'($urandom));
            n = $urandom_range(1, 10);
            q_g.delete(); hin_g.delete(); fin_g.delete();
            for (int j = 0; j < n; j++) begin
                q_g.push_back(int'($urandom_range(0, 3)));
                hin_g.push_back(int'($urandom_range(0, 30)));
                fin_g.push_back(int'($urandom_range(0, 30)));
            end
            run_query(1, (it % 2 == 1), v, (it % 5 == 4), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
